// File: rtl/data_store_buffer.sv
// data_store_buffer: four-entry in-order store buffer with coalescing, store-to-load forwarding and flush
// Ports:
//   iClk, iRst                 clock, asynchronous active-high reset
//   iStoreValid/Addr/Data/Mask store offer; oStoreReady says it can be taken
//   iLoadAddr -> oFwdMask/Data buffered bytes for a younger load
//   oMemWriteEn/Addr/Data/Mask head entry toward memory, retired on iMemReady
//   iFlush -> oFlushDone       drain request and its one-cycle completion pulse
//   oEmpty                     no valid entries
module data_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iStoreValid,
    input  logic [DATA_WIDTH-1:0]   iStoreAddr,
    input  logic [DATA_WIDTH-1:0]   iStoreData,
    input  logic [DATA_WIDTH/8-1:0] iStoreMask,
    output logic                    oStoreReady,
    input  logic [DATA_WIDTH-1:0]   iLoadAddr,
    output logic [DATA_WIDTH/8-1:0] oFwdMask,
    output logic [DATA_WIDTH-1:0]   oFwdData,
    output logic                    oMemWriteEn,
    output logic [DATA_WIDTH-1:0]   oMemAddr,
    output logic [DATA_WIDTH-1:0]   oMemData,
    output logic [DATA_WIDTH/8-1:0] oMemMask,
    input  logic                    iMemReady,
    input  logic                    iFlush,
    output logic                    oEmpty,
    output logic                    oFlushDone
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = DATA_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSHING} state_t;

    state_t                  state;
    logic [PW-1:0]           head, tail, young, idx;
    logic [CW-1:0]           count, count_next;
    logic [AW-1:0]           word [DEPTH];
    logic [DATA_WIDTH-1:0]   data [DEPTH];
    logic [MW-1:0]           mask [DEPTH];
    logic                    push, coalesce, pop, flush_done;
    logic [DATA_WIDTH-1:0]   lane_bits;

    assign young       = tail - PW'(1);
    assign oEmpty      = count == '0;
    assign oStoreReady = count < CW'(DEPTH) && state != FLUSHING;
    assign push        = iStoreValid && oStoreReady && |iStoreMask;
    // count>=2 keeps the merge target away from the head being presented to memory
    assign coalesce    = push && count >= CW'(2) && word[young] == iStoreAddr[DATA_WIDTH-1:2];
    assign pop         = !oEmpty && iMemReady;
    assign count_next  = count + CW'(push && !coalesce) - CW'(pop);
    assign oMemWriteEn = !oEmpty;
    assign oMemAddr    = oEmpty ? '0 : {word[head], 2'b00};
    assign oMemData    = oEmpty ? '0 : data[head];
    assign oMemMask    = oEmpty ? '0 : mask[head];
    assign oFlushDone  = flush_done;

    always_comb begin
        lane_bits = '0;
        for (int l = 0; l < MW; l++) lane_bits[l*8 +: 8] = {8{iStoreMask[l]}};
    end

    // Walk oldest to youngest so younger matching lanes overwrite older ones
    always_comb begin
        oFwdMask = '0;
        oFwdData = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && word[idx] == iLoadAddr[DATA_WIDTH-1:2])
                for (int l = 0; l < MW; l++)
                    if (mask[idx][l]) begin
                        oFwdMask[l]          = 1'b1;
                        oFwdData[l*8 +: 8]   = data[idx][l*8 +: 8];
                    end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            flush_done <= 1'b0;
        end else begin
            count      <= count_next;
            flush_done <= 1'b0;
            if (push && !coalesce) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            case (state)
                IDLE: begin
                    if (push) state <= ACTIVE;
                    if (iFlush) flush_done <= 1'b1;
                end
                ACTIVE: begin
                    if (count_next == '0) begin
                        state      <= IDLE;
                        flush_done <= iFlush;
                    end else if (iFlush) state <= FLUSHING;
                end
                FLUSHING: begin
                    if (count_next == '0) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry payload needs no reset: validity comes from head/count
    always_ff @(posedge iClk) begin
        if (coalesce) begin
            data[young] <= (data[young] & ~lane_bits) | (iStoreData & lane_bits);
            mask[young] <= mask[young] | iStoreMask;
        end else if (push) begin
            word[tail] <= iStoreAddr[DATA_WIDTH-1:2];
            data[tail] <= iStoreData;
            mask[tail] <= iStoreMask;
        end
    end
endmodule

// File: doc/data_store_buffer.md
# data_store_buffer

Four-entry write buffer between the execute/memory-stage store path and the data memory. Accepts byte-masked stores in one cycle, retires them in order to the data memory through a ready/valid handshake, coalesces back-to-back stores to the same word, and forwards buffered bytes to younger loads so the load path never reads stale memory.

## Interface
- DATA_WIDTH, 32: data and address width.
- DEPTH, 4: entry count, power of two, ≥2.
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  reset; asynchronous and active-high.
- iStoreValid  in  1  store offered this cycle.
- iStoreAddr  in  32  byte address; bits [1:0] ignored (word index = [31:2]).
- iStoreData  in  32  store data, already lane-aligned.
- iStoreMask  in  4  byte enables, bit n selects byte lane n.
- oStoreReady  out  1  buffer can accept a store this cycle.
- iLoadAddr  in  32  load address for forwarding lookup.
- oFwdMask  out  4  lanes supplied by the buffer.
- oFwdData  out  32  forwarded bytes; lanes with oFwdMask=0 are 0.
- oMemWriteEn  out  1  head entry valid toward memory.
- oMemAddr  out  32  head word address, {word, 2'b00}.
- oMemData  out  32  head data.
- oMemMask  out  4  head byte enables.
- iMemReady  in  1  memory accepts head this cycle.
- iFlush  in  1  one-cycle drain request.
- oEmpty  out  1  no valid entries.
- oFlushDone  out  1  one-cycle pulse when a flush completes.

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits (wrap modulo DEPTH), count of $clog2(DEPTH)+1 bits.
- Push: iStoreValid && oStoreReady && iStoreMask≠0. Mask 0 stores are dropped, no state change.
- Coalesce: if count≥2 and youngest entry (tail-1) word index equals store word index, merge bytes into that entry under iStoreMask (mask ORed); count unchanged. Never coalesce into head (it is being presented to memory).
- Otherwise write entry at tail, tail+1, count+1.
- Pop: oMemWriteEn && iMemReady; head+1, count-1.
- Push and pop same cycle: both take effect; count net unchanged (or -1 if push coalesced).
- oStoreReady = (count<DEPTH) && state≠FLUSHING. Full buffer refuses stores even when a pop occurs that cycle.
- Memory outputs are combinational from head entry; all zero when empty.
- Forwarding (combinational): per lane, youngest valid entry whose word index matches iLoadAddr[31:2] and has that mask bit supplies the byte. Entry popping this cycle still forwards; a store pushed this cycle does not.
- FSM: IDLE (count=0), ACTIVE (count>0), FLUSHING.
  - IDLE→ACTIVE on push; ACTIVE→IDLE when count reaches 0.
  - iFlush in IDLE: oFlushDone next cycle, stay IDLE.
  - iFlush in ACTIVE → FLUSHING; stores refused; FLUSHING→IDLE on cycle count reaches 0, oFlushDone high for the following cycle.
  - iFlush in FLUSHING ignored.

## Timing
- Reset: count 0, pointers 0, state IDLE, entries invalid; oStoreReady 1, oEmpty 1, oMemWriteEn 0, oMemAddr/oMemData/oMemMask 0, oFwdMask 0, oFwdData 0, oFlushDone 0.
- Reset mid-flush or mid-drain discards all entries immediately; no further memory writes.
- Store accepted at edge N is visible on oMemWriteEn/forward outputs after edge N (cycle N+1) if buffer was empty.
- Retirement latency with iMemReady held high: one entry per cycle, in order.
- oFlushDone is registered, exactly one cycle wide.
- oEmpty = (count==0), combinational from registered count.

## Test plan
- Reset, then store 0x1000 data 0xDEADBEEF mask 4'b1111 with iMemReady=0 → next cycle oMemWriteEn=1, oMemAddr=0x1000, oMemData=0xDEADBEEF, oEmpty=0; raise iMemReady one cycle → oEmpty=1.
- iMemReady=0, push 4 stores to 0x0,0x4,0x8,0xC → oStoreReady=0; fifth store ignored; then iMemReady=1 drains in order 0x0,0x4,0x8,0xC over 4 cycles.
- Stores 0x100 mask 0001 data 0x11, then 0x200 mask 1111, then 0x200 mask 0100 data 0x00AA0000 → count stays 2, entry 0x200 data byte2=0xAA.
- Buffer holds 0x40 data 0x11223344 mask 1111 and younger 0x40 data 0x0000BB00 mask 0010 (non-coalesced, head younger not applicable: push with head at 0x40 only) → iLoadAddr 0x42 gives oFwdMask=1111, oFwdData=0x1122BB44.
- Three entries, iFlush pulse, iMemReady toggling → oStoreReady=0 throughout, oFlushDone single pulse one cycle after last pop, then oStoreReady=1.
- Assert iRst while FLUSHING with 2 entries → outputs return to reset values asynchronously; no oMemWriteEn after release.
